nim_scaler: RTL and testbench
=============================

Name: nim_scaler

Overview:
- Per-channel pulse scaler downstream of the NIM+ trigger logic.
- Counts rising edges on the 12 processed input lines and the 4 NIM output lines, 16 channels by default.
- Periodically snapshots the live counts into a readout register bank exposed through params_out.
- Gate period and control bits come from params_in.

Parameters:
- N_CH, 16, number of counted channels (bit i of trig_in maps to channel i).
- CNT_W, 32, live/snapshot counter width.
- GATE_W, 32, gate-period counter width, in clk cycles.

Ports:
- clk  input  1  fast fabric clock; all logic in this domain.
- reset  input  1  asynchronous, active-high reset.
- trig_in  input  N_CH  processed trigger lines, synchronous to clk.
- enable  input  1  level; 1 = count and run the gate timer.
- clear  input  1  single-cycle pulse; zero live counters, overflow flags and gate timer.
- snapshot_req  input  1  single-cycle pulse; force an immediate snapshot.
- gate_period  input  GATE_W  gate length in cycles; 0 = no automatic snapshots.
- counts_out  output  N_CH*CNT_W  snapshot bank; channel i at [i*CNT_W +: CNT_W].
- overflow_out  output  N_CH  per-channel saturation flags captured with the snapshot.
- counts_valid  output  1  one-cycle pulse coincident with new counts_out.
- snap_seq  output  16  snapshot sequence number; increments per snapshot, wraps 0xFFFF->0.

Behaviour:
- Reset, asynchronous: all outputs 0; live counters, overflow flags, gate timer and edge registers 0; state IDLE.
- Edge detect per channel: trig_q <= trig_in; trig_qq <= trig_q; edge = trig_q & ~trig_qq.
  - A 0->1 on trig_in at edge N is added to the live count at edge N+2.
  - A level held high counts once.
  - A 1-cycle pulse counts once.
- State machine:
  - IDLE -> RUN when enable=1; the gate timer loads gate_period-1 on entry.
  - RUN -> IDLE when enable=0; live counters and timer hold their values.
  - Edges are counted only in RUN. Edge registers keep updating in IDLE, so re-enabling never creates a spurious count.
- Live counter:
  - Increments by 1 on edge in RUN.
  - At all-ones it saturates (holds) and sets the sticky overflow flag for that channel.
- Gate timer:
  - Active only in RUN with gate_period != 0. Decrements each cycle.
  - At 0 it triggers a snapshot and reloads gate_period-1.
  - A gate_period change takes effect at the next reload.
  - gate_period=1 snapshots every cycle.
- Snapshot, single-cycle action:
  - counts_out <= live counts including any edge in the snapshot cycle.
  - overflow_out <= live flags.
  - Live counters and flags zero on the same edge, so no edge is lost or double-counted.
  - counts_valid = 1 for that one cycle; snap_seq increments.
- snapshot_req:
  - Honoured in RUN and IDLE.
  - Also reloads the gate timer.
  - Coincident with a gate terminal count, exactly one snapshot occurs.
- clear:
  - Zeroes live counters, flags and the timer (reload gate_period-1 if in RUN).
  - Leaves counts_out, overflow_out and snap_seq unchanged.
  - Edges in the clear cycle are discarded.
  - clear with a simultaneous snapshot_req or terminal count: clear wins; no snapshot, counts_valid stays 0.
- Reset mid-gate: everything returns to reset values immediately; the first gate after release is a full gate_period.

Decomposition:
- Package nim_scaler_pkg:
  - state enum {IDLE, RUN};
  - default widths CNT_W/GATE_W/N_CH;
  - localparam SEQ_W = 16;
  - the params_in/params_out struct fields for scaler control and readout (enable, clear, snapshot_req, gate_period, counts, overflow, seq).
- Sub-module nim_scaler_channel (generated N_CH times): two-flop edge detect, saturating counter, sticky overflow, snapshot/clear inputs.
- Top level: FSM, gate timer, snapshot bank, sequence counter.

Test Plan:
- Reset and idle: assert reset; pulse trig_in[0] 5 times with enable=0 -> counts_out all 0, counts_valid never 1, snap_seq=0.
- Gated rate count: enable=1, gate_period=100; drive a 1-cycle pulse on ch3 every 10 cycles -> counts_valid every 100 cycles, ch3 count 10, snap_seq 1,2,3…; other channels 0.
- Boundary edge: pulse lands exactly in the terminal-count cycle -> counted in the closing gate; next gate starts at 0; the sum over gates equals total pulses.
- Saturation: CNT_W=4, 20 edges on ch0 in one gate -> ch0 count 15, overflow_out[0]=1, and 0 in the following empty gate.
- Simultaneity: snapshot_req on the terminal cycle -> one counts_valid pulse, snap_seq +1. clear with snapshot_req -> no counts_valid, live zeroed, counts_out unchanged.
- Enable toggle and level input: hold trig_in[5]=1 across enable 0->1 -> no count. Drop enable mid-gate for 50 cycles -> the gate stretches by 50 cycles and the count is held.

Source files
------------

// File: rtl/nim_scaler_pkg.sv
// rtl/nim_scaler_pkg.sv - shared types, default widths and readout field layout for the NIM pulse scaler
package nim_scaler_pkg;

   localparam int DEF_N_CH   = 16;
   localparam int DEF_CNT_W  = 32;
   localparam int DEF_GATE_W = 32;
   localparam int SEQ_W      = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic                  enable;
      logic                  clear;
      logic                  snapshot_req;
      logic [DEF_GATE_W-1:0] gate_period;
   } params_in_t;

   typedef struct packed {
      logic [DEF_N_CH*DEF_CNT_W-1:0] counts;
      logic [DEF_N_CH-1:0]           overflow;
      logic [SEQ_W-1:0]              seq;
   } params_out_t;

endpackage

// File: rtl/nim_scaler_channel.sv
// rtl/nim_scaler_channel.sv - one scaler channel: two-flop edge detect, saturating live counter, sticky overflow
module nim_scaler_channel
   import nim_scaler_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             trig,
   input  logic             run,
   input  logic             snap,
   input  logic             clear,
   output logic [CNT_W-1:0] snap_count,
   output logic             snap_overflow
);

   logic             trig_q;
   logic             trig_qq;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic             edge_det;
   logic             inc;
   logic             sat;

   assign edge_det = trig_q & ~trig_qq;
   assign inc      = run & edge_det & ~clear;
   assign sat      = &count;

   // The snapshot bank samples these, so an edge in the snapshot cycle lands in the closing gate.
   assign snap_count    = (inc && !sat) ? count + CNT_W'(1) : count;
   assign snap_overflow = overflow | (inc & sat);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trig_q   <= 1'b0;
         trig_qq  <= 1'b0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         trig_q  <= trig;
         trig_qq <= trig_q;
         if (clear || snap) begin
            count    <= '0;
            overflow <= 1'b0;
         end else begin
            count    <= snap_count;
            overflow <= snap_overflow;
         end
      end
   end

endmodule

// File: rtl/nim_scaler.sv
// rtl/nim_scaler.sv - per-channel pulse scaler with gate timer, snapshot readout bank and sequence counter
module nim_scaler
   import nim_scaler_pkg::*;
#(
   parameter int N_CH   = DEF_N_CH,
   parameter int CNT_W  = DEF_CNT_W,
   parameter int GATE_W = DEF_GATE_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_CH-1:0]       trig_in,
   input  logic                  enable,
   input  logic                  clear,
   input  logic                  snapshot_req,
   input  logic [GATE_W-1:0]     gate_period,
   output logic [N_CH*CNT_W-1:0] counts_out,
   output logic [N_CH-1:0]       overflow_out,
   output logic                  counts_valid,
   output logic [SEQ_W-1:0]      snap_seq
);

   state_t                state;
   logic [GATE_W-1:0]     timer;
   logic [GATE_W-1:0]     reload;
   logic                  armed;
   logic                  run;
   logic                  terminal;
   logic                  snap;
   logic [N_CH*CNT_W-1:0] snap_bank;
   logic [N_CH-1:0]       snap_ovf;

   assign run      = (state == RUN);
   assign reload   = (gate_period == '0) ? '0 : gate_period - GATE_W'(1);
   assign terminal = run && (gate_period != '0) && (timer == '0);
   assign snap     = (terminal || snapshot_req) && !clear;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      nim_scaler_channel #(.CNT_W(CNT_W)) u_ch (
         .clk           (clk),
         .reset         (reset),
         .trig          (trig_in[i]),
         .run           (run),
         .snap          (snap),
         .clear         (clear),
         .snap_count    (snap_bank[i*CNT_W +: CNT_W]),
         .snap_overflow (snap_ovf[i])
      );
   end

   // armed marks a timer holding a live gate position, so re-entering RUN resumes rather than restarts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         timer        <= '0;
         armed        <= 1'b0;
         counts_out   <= '0;
         overflow_out <= '0;
         counts_valid <= 1'b0;
         snap_seq     <= '0;
      end else begin
         case (state)
            IDLE: if (enable)  state <= RUN;
            RUN:  if (!enable) state <= IDLE;
         endcase

         if (clear) begin
            if (run || enable) begin
               timer <= reload;
               armed <= 1'b1;
            end else begin
               timer <= '0;
               armed <= 1'b0;
            end
         end else if (snapshot_req || terminal || (!run && enable && !armed)) begin
            timer <= reload;
            armed <= 1'b1;
         end else if (run && gate_period != '0) begin
            timer <= timer - GATE_W'(1);
         end

         counts_valid <= snap;
         if (snap) begin
            counts_out   <= snap_bank;
            overflow_out <= snap_ovf;
            snap_seq     <= snap_seq + SEQ_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_nim_scaler.sv
// tb/tb_nim_scaler.sv - directed self-checking bench for nim_scaler (default widths plus a 4-bit counter instance)
module tb_nim_scaler;

   localparam int NC  = 16;
   localparam int CW  = 32;
   localparam int CW4 = 4;
   localparam int GW  = 32;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NC-1:0]     trig_in = '0;
   logic              enable = 1'b0;
   logic              clear = 1'b0;
   logic              snapshot_req = 1'b0;
   logic [GW-1:0]     gate_period = '0;

   logic [NC*CW-1:0]  counts_out;
   logic [NC-1:0]     overflow_out;
   logic              counts_valid;
   logic [15:0]       snap_seq;

   logic [NC*CW4-1:0] counts4;
   logic [NC-1:0]     ovf4;
   logic              valid4;
   logic [15:0]       seq4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   nim_scaler #(.N_CH(NC), .CNT_W(CW), .GATE_W(GW)) dut (
      .clk(clk), .reset(reset), .trig_in(trig_in), .enable(enable), .clear(clear),
      .snapshot_req(snapshot_req), .gate_period(gate_period), .counts_out(counts_out),
      .overflow_out(overflow_out), .counts_valid(counts_valid), .snap_seq(snap_seq)
   );

   nim_scaler #(.N_CH(NC), .CNT_W(CW4), .GATE_W(GW)) dut4 (
      .clk(clk), .reset(reset), .trig_in(trig_in), .enable(enable), .clear(clear),
      .snapshot_req(snapshot_req), .gate_period(gate_period), .counts_out(counts4),
      .overflow_out(ovf4), .counts_valid(valid4), .snap_seq(seq4)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; enable = 1'b0; clear = 1'b0; snapshot_req = 1'b0;
      trig_in = '0; gate_period = '0;
      step(); step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (counts_out !== '0) begin errors++; $display("FAIL reset_counts got=%h exp=0", counts_out); end
      checks++; if (overflow_out !== '0) begin errors++; $display("FAIL reset_ovf got=%h exp=0", overflow_out); end
      checks++; if (counts_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", counts_valid); end
      checks++; if (snap_seq !== 16'd0) begin errors++; $display("FAIL reset_seq got=%0d exp=0", snap_seq); end
      for (int i = 0; i < 5; i++) begin
         trig_in[0] = 1'b1; step();
         checks++; if (counts_valid !== 1'b0) begin errors++; $display("FAIL idle_valid i=%0d got=%b exp=0", i, counts_valid); end
         trig_in[0] = 1'b0; step();
         checks++; if (counts_valid !== 1'b0) begin errors++; $display("FAIL idle_valid i=%0d got=%b exp=0", i, counts_valid); end
      end
      checks++; if (counts_out !== '0) begin errors++; $display("FAIL idle_counts got=%h exp=0", counts_out); end
      checks++; if (snap_seq !== 16'd0) begin errors++; $display("FAIL idle_seq got=%0d exp=0", snap_seq); end
      snapshot_req = 1'b1; step(); snapshot_req = 1'b0;
      checks++; if (counts_valid !== 1'b1) begin errors++; $display("FAIL idle_req_valid got=%b exp=1", counts_valid); end
      checks++; if (snap_seq !== 16'd1) begin errors++; $display("FAIL idle_req_seq got=%0d exp=1", snap_seq); end
      checks++; if (counts_out !== '0) begin errors++; $display("FAIL idle_req_counts got=%h exp=0", counts_out); end
      step();
      checks++; if (counts_valid !== 1'b0) begin errors++; $display("FAIL idle_req_pulse got=%b exp=0", counts_valid); end
      #2 reset = 1'b1;
      #1;
      checks++; if (snap_seq !== 16'd0) begin errors++; $display("FAIL async_reset_seq got=%0d exp=0", snap_seq); end
      step();
      reset = 1'b0;
   endtask

   task automatic test_gated_rate();
      logic [NC*CW-1:0] exp_bank;
      logic             exp_v;
      int               exp_seq;
      do_reset();
      exp_bank = '0; exp_seq = 0;
      enable = 1'b1; gate_period = 32'd100;
      for (int c = 0; c < 300; c++) begin
         trig_in[3] = (c % 10 == 0);
         step();
         exp_v = (c + 1 >= 101) && ((c + 1) % 100 == 1);
         if (exp_v) begin
            exp_bank = '0; exp_bank[3*CW +: CW] = 32'd10; exp_seq++;
         end
         checks++; if (counts_valid !== exp_v) begin errors++; $display("FAIL rate_valid c=%0d got=%b exp=%b", c, counts_valid, exp_v); end
         checks++; if (counts_out !== exp_bank) begin errors++; $display("FAIL rate_counts c=%0d got=%h exp=%h", c, counts_out, exp_bank); end
         checks++; if (snap_seq !== 16'(exp_seq)) begin errors++; $display("FAIL rate_seq c=%0d got=%0d exp=%0d", c, snap_seq, exp_seq); end
      end
   endtask

   task automatic test_boundary();
      logic [NC*CW-1:0] exp_bank;
      logic             exp_v;
      int               sum;
      do_reset();
      exp_bank = '0; sum = 0;
      enable = 1'b1; gate_period = 32'd10;
      for (int c = 0; c < 35; c++) begin
         trig_in[7] = (c == 9 || c == 11 || c == 19 || c == 25);
         step();
         exp_v = (c + 1 == 11 || c + 1 == 21 || c + 1 == 31);
         if (c + 1 == 11) exp_bank[7*CW +: CW] = 32'd1;
         if (c + 1 == 21) exp_bank[7*CW +: CW] = 32'd2;
         if (c + 1 == 31) exp_bank[7*CW +: CW] = 32'd1;
         if (counts_valid === 1'b1) sum += int'(counts_out[7*CW +: CW]);
         checks++; if (counts_valid !== exp_v) begin errors++; $display("FAIL bound_valid c=%0d got=%b exp=%b", c, counts_valid, exp_v); end
         checks++; if (counts_out !== exp_bank) begin errors++; $display("FAIL bound_counts c=%0d got=%h exp=%h", c, counts_out, exp_bank); end
      end
      checks++; if (sum !== 4) begin errors++; $display("FAIL bound_sum got=%0d exp=4", sum); end
   endtask

   task automatic test_saturation();
      logic [NC*CW-1:0]  exp_bank;
      logic [NC*CW4-1:0] exp4;
      logic [NC-1:0]     exp_ovf4;
      logic              exp_v;
      do_reset();
      exp_bank = '0; exp4 = '0; exp_ovf4 = '0;
      enable = 1'b1; gate_period = 32'd50;
      for (int c = 0; c < 101; c++) begin
         trig_in[0] = (c < 40) && (c % 2 == 0);
         step();
         exp_v = (c + 1 == 51 || c + 1 == 101);
         if (c + 1 == 51) begin
            exp_bank[0 +: CW] = 32'd20; exp4[0 +: CW4] = 4'd15; exp_ovf4 = 16'h0001;
         end
         if (c + 1 == 101) begin
            exp_bank = '0; exp4 = '0; exp_ovf4 = '0;
         end
         checks++; if (valid4 !== exp_v) begin errors++; $display("FAIL sat_valid c=%0d got=%b exp=%b", c, valid4, exp_v); end
         checks++; if (counts4 !== exp4) begin errors++; $display("FAIL sat_counts4 c=%0d got=%h exp=%h", c, counts4, exp4); end
         checks++; if (ovf4 !== exp_ovf4) begin errors++; $display("FAIL sat_ovf4 c=%0d got=%h exp=%h", c, ovf4, exp_ovf4); end
         checks++; if (counts_out !== exp_bank) begin errors++; $display("FAIL sat_counts32 c=%0d got=%h exp=%h", c, counts_out, exp_bank); end
         checks++; if (overflow_out !== '0) begin errors++; $display("FAIL sat_ovf32 c=%0d got=%h exp=0", c, overflow_out); end
      end
   endtask

   task automatic test_simultaneous();
      logic [NC*CW-1:0] exp_bank;
      logic             exp_v;
      int               exp_seq;
      do_reset();
      exp_bank = '0; exp_seq = 0;
      enable = 1'b1; gate_period = 32'd20;
      for (int c = 0; c < 56; c++) begin
         trig_in[2]   = (c == 5 || c == 25 || c == 35);
         snapshot_req = (c == 20 || c == 30);
         clear        = (c == 30);
         step();
         exp_v = (c + 1 == 21 || c + 1 == 51);
         if (exp_v) begin
            exp_bank[2*CW +: CW] = 32'd1; exp_seq++;
         end
         checks++; if (counts_valid !== exp_v) begin errors++; $display("FAIL simul_valid c=%0d got=%b exp=%b", c, counts_valid, exp_v); end
         checks++; if (counts_out !== exp_bank) begin errors++; $display("FAIL simul_counts c=%0d got=%h exp=%h", c, counts_out, exp_bank); end
         checks++; if (snap_seq !== 16'(exp_seq)) begin errors++; $display("FAIL simul_seq c=%0d got=%0d exp=%0d", c, snap_seq, exp_seq); end
      end
      snapshot_req = 1'b0; clear = 1'b0;
   endtask

   task automatic test_enable_toggle();
      logic [NC*CW-1:0] exp_bank;
      logic             exp_v;
      do_reset();
      exp_bank = '0;
      trig_in[5] = 1'b1;
      for (int i = 0; i < 5; i++) step();
      gate_period = 32'd30;
      for (int c = 0; c < 90; c++) begin
         enable     = !(c >= 10 && c < 60);
         trig_in[4] = (c == 5 || c == 30 || c == 65);
         step();
         exp_v = (c + 1 == 81);
         if (exp_v) exp_bank[4*CW +: CW] = 32'd2;
         checks++; if (counts_valid !== exp_v) begin errors++; $display("FAIL toggle_valid c=%0d got=%b exp=%b", c, counts_valid, exp_v); end
         checks++; if (counts_out !== exp_bank) begin errors++; $display("FAIL toggle_counts c=%0d got=%h exp=%h", c, counts_out, exp_bank); end
      end
   endtask

   task automatic test_gate_one();
      logic [NC*CW-1:0] exp_bank;
      logic             exp_v;
      do_reset();
      enable = 1'b1; gate_period = 32'd1;
      for (int c = 0; c < 6; c++) begin
         trig_in[1] = (c == 0 || c == 2);
         step();
         exp_v = (c + 1 >= 2);
         exp_bank = '0;
         if (c + 1 == 2 || c + 1 == 4) exp_bank[1*CW +: CW] = 32'd1;
         checks++; if (counts_valid !== exp_v) begin errors++; $display("FAIL gate1_valid c=%0d got=%b exp=%b", c, counts_valid, exp_v); end
         checks++; if (counts_out !== exp_bank) begin errors++; $display("FAIL gate1_counts c=%0d got=%h exp=%h", c, counts_out, exp_bank); end
         checks++; if (snap_seq !== 16'(c)) begin errors++; $display("FAIL gate1_seq c=%0d got=%0d exp=%0d", c, snap_seq, c); end
      end
   endtask

   initial begin
      test_reset();
      test_gated_rate();
      test_boundary();
      test_saturation();
      test_simultaneous();
      test_enable_toggle();
      test_gate_one();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
